reg_bank_scanner: RTL and testbench
===================================

# reg_bank_scanner

- Downstream consumer of the 8-channel register bank, which presents eight `Width`-bit values on a_..h_ outputs.
- Watches all eight channels and detects value changes.
- Arbitrates among changed channels round-robin and emits one `{index, value}` record per transfer on a valid/ready stream.
- Gives later stages a compact change-event feed instead of eight parallel buses.

## Interface

- `Width`, default 8: channel data width.
- `clk_i`, input, 1: sole clock, rising edge.
- `rst_ni`, input, 1: asynchronous active-low reset.
- `a_i` .. `h_i`, input, `Width` each: channel values 0..7 (a=0 … h=7), driven by the register bank.
- `valid_o`, output, 1: a record is presented.
- `ready_i`, input, 1: consumer accepts the record.
- `idx_o`, output, 3: channel index of the record.
- `data_o`, output, `Width`: channel value of the record.
- `pend_o`, output, 8: pending-change bitmap (debug).
- `ovf_cnt_o`, output, 16: lost-update count (see Configuration).

## Operation

- Per channel k, three pieces of state:
  - sample register `smp[k]`;
  - pending bit `pend[k]`;
  - round-robin pointer `ptr` (3 bit), shared across channels.
- Every edge: `smp[k] <= in[k]`.
- If `in[k] != smp[k]`, set `pend[k]`.
- FSM has two states, IDLE and SEND.
- IDLE:
  - If `pend != 0`, grant the first set bit searching upward from `ptr` with wrap 7→0.
  - Load `idx_o = k`, `data_o = smp[k]` and clear `pend[k]`.
  - Set `ptr = k+1` (mod 8), assert `valid_o` and go to SEND.
- SEND:
  - `idx_o`/`data_o` hold stable while `valid_o && !ready_i`.
  - On `ready_i` with `pend` still nonzero (evaluated after this cycle's clear), grant the next channel on the same edge. This gives back-to-back records, one per cycle.
  - On `ready_i` with no pending channel, deassert `valid_o` and go to IDLE.
- Simultaneous grant and new change on the same channel: the clear loses and `pend[k]` stays set. The record carries the pre-change `smp[k]`; the new value is emitted on a later grant.
- Multiple changes to one channel before its grant collapse into one record, which carries the latest sampled value.
- `valid_o` never drops without a handshake.

## Timing

- Reset (async assert, sync release) forces:
  - `valid_o` = 0, `idx_o` = 0, `data_o` = 0, `pend_o` = 0, `ovf_cnt_o` = 0;
  - `smp` = 0, `ptr` = 0, state IDLE.
- Any nonzero input after reset counts as a change.
- Latency:
  - Input changes before edge E → `pend[k]` set at E.
  - If idle, `valid_o` = 1 after E+1, so 2 cycles from input change to valid.
- Throughput: 1 record/cycle while `ready_i` is held high.
- Reset mid-transfer drops the presented record and all pending changes. No partial state survives.
- Worst-case wait for any pending channel: 7 grants.

## Configuration

- Macro: `REG_BANK_SCANNER_OVF_EN`.
- Defined:
  - `ovf_cnt_o` counts edges where a change is detected on channel k while `pend[k]` is already set and not granted that edge.
  - Saturates at 16'hFFFF; cleared only by reset.
- Undefined:
  - No counter logic is built.
  - `ovf_cnt_o` is tied to 0; the port remains present.

## Test plan

- Reset, all inputs 0, hold 10 cycles → `valid_o` stays 0, `pend_o` = 8'h00.
- `c_i` = 8'h5A at cycle 0, `ready_i` = 1 → `valid_o` high at cycle 2 with `idx_o` = 2, `data_o` = 8'h5A, for exactly 1 cycle.
- Change channels 1, 4, 6 on the same edge, `ready_i` = 1, `ptr` = 0 → three back-to-back records with idx 1, 4, 6, then `valid_o` drops.
- Same as above with `ready_i` = 0 for 5 cycles → idx 1 and its data held stable all 5 cycles; the remaining records follow once `ready_i` = 1.
- `e_i` goes 1→2→3 on consecutive edges while stalled → one record idx 4, `data_o` = 3.
  - With macro: `ovf_cnt_o` = 2.
  - Without macro: `ovf_cnt_o` = 0.
- `rst_ni` pulsed low while `valid_o` is high with 3 channels pending → outputs immediately return to reset values. With inputs unchanged and nonzero, fresh records are emitted starting at idx 0 order.

Source files
------------

// File: rtl/reg_bank_scanner.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_scanner
// Purpose  : Samples the eight register-bank channels every cycle and flags
//            any channel whose value changed. Pending channels are served
//            round-robin, one {index, value} record per valid/ready transfer.
// Options  : REG_BANK_SCANNER_OVF_EN builds the saturating lost-update
//            counter on ovf_cnt_o. Without it, ovf_cnt_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_scanner #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [Width-1:0] c_i,
  input  logic [Width-1:0] d_i,
  input  logic [Width-1:0] e_i,
  input  logic [Width-1:0] f_i,
  input  logic [Width-1:0] g_i,
  input  logic [Width-1:0] h_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [2:0]       idx_o,
  output logic [Width-1:0] data_o,
  output logic [7:0]       pend_o,
  output logic [15:0]      ovf_cnt_o
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [Width-1:0] chan_in [8];
  logic [Width-1:0] smp_q   [8];
  logic [7:0]       change;
  logic [7:0]       clr;
  logic [7:0]       pend_q, pend_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       idx_q, idx_d;
  logic [Width-1:0] data_q, data_d;
  logic [2:0]       cand;
  logic [2:0]       gnt_idx;
  logic             gnt_found;
  logic             take;

  assign chan_in[0] = a_i;
  assign chan_in[1] = b_i;
  assign chan_in[2] = c_i;
  assign chan_in[3] = d_i;
  assign chan_in[4] = e_i;
  assign chan_in[5] = f_i;
  assign chan_in[6] = g_i;
  assign chan_in[7] = h_i;

  // A channel has changed when its live value differs from last cycle's sample.
  for (genvar k = 0; k < 8; k++) begin : g_chan
    assign change[k] = (chan_in[k] != smp_q[k]);
  end

  // Sample every channel on every edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 8; k++) smp_q[k] <= '0;
    end else begin
      for (int k = 0; k < 8; k++) smp_q[k] <= chan_in[k];
    end
  end

  // Round-robin search: first pending channel at or above ptr, wrapping 7->0.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!gnt_found && pend_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Next-state and grant logic: a grant happens from IDLE or on a handshake.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    data_d  = data_q;
    clr     = 8'h00;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        take = gnt_found;
      end
      SEND: begin
        if (ready_i) begin
          if (gnt_found) take = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d      = SEND;
      idx_d        = gnt_idx;
      data_d       = smp_q[gnt_idx];
      clr[gnt_idx] = 1'b1;
      ptr_d        = gnt_idx + 3'd1;
    end
  end

  // A change arriving on the same edge as the grant wins over the clear.
  assign pend_d = (pend_q & ~clr) | change;

  // State, pointer, record and pending registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      idx_q   <= 3'd0;
      data_q  <= '0;
      pend_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

  assign valid_o = (state_q == SEND);
  assign idx_o   = idx_q;
  assign data_o  = data_q;
  assign pend_o  = pend_q;

`ifdef REG_BANK_SCANNER_OVF_EN
  logic        lost;
  logic [15:0] ovf_q, ovf_d;

  // An update is lost when a channel changes again before its grant.
  assign lost  = |(change & pend_q & ~clr);
  assign ovf_d = (lost && (ovf_q != 16'hFFFF)) ? ovf_q + 16'd1 : ovf_q;

  // Saturating lost-update counter, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ovf_q <= 16'h0000;
    else         ovf_q <= ovf_d;
  end

  assign ovf_cnt_o = ovf_q;
`else
  assign ovf_cnt_o = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_scanner
// Purpose  : Self-checking bench for reg_bank_scanner: directed scenarios
//            followed by random channel/ready traffic, all compared against
//            an event-level reference model of the scanner.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ch [8];
  logic        rdy = 1'b1;
  logic        valid;
  logic [2:0]  idx;
  logic [7:0]  data;
  logic [7:0]  pend;
  logic [15:0] ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-channel last-seen value, set of pending channels,
  // the record currently offered, and the next channel to favour.
  logic [7:0] m_smp [8];
  bit   [7:0] m_pend;
  int         m_ptr;
  bit         m_valid;
  int         m_idx;
  logic [7:0] m_data;
  int         m_ovf;

  reg_bank_scanner #(.Width(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .a_i      (ch[0]),
    .b_i      (ch[1]),
    .c_i      (ch[2]),
    .d_i      (ch[3]),
    .e_i      (ch[4]),
    .f_i      (ch[5]),
    .g_i      (ch[6]),
    .h_i      (ch[7]),
    .valid_o  (valid),
    .ready_i  (rdy),
    .idx_o    (idx),
    .data_o   (data),
    .pend_o   (pend),
    .ovf_cnt_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_smp[k] = 8'h00;
    m_pend  = 8'h00;
    m_ptr   = 0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_data  = 8'h00;
    m_ovf   = 0;
  endtask

  // One clock edge of the scanner's behaviour, using the inputs as applied.
  task automatic model_step();
    int         g = -1;
    bit         lost = 1'b0;
    bit   [7:0] np;
    if (!m_valid || rdy) begin
      for (int i = 0; i < 8; i++)
        if (g < 0 && m_pend[(m_ptr + i) % 8]) g = (m_ptr + i) % 8;
      if (g >= 0) begin
        m_idx   = g;
        m_data  = m_smp[g];
        m_ptr   = (g + 1) % 8;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    np = m_pend;
    if (g >= 0) np[g] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (ch[k] != m_smp[k]) begin
        if (m_pend[k] && k != g) lost = 1'b1;
        np[k] = 1'b1;
      end
    end
    m_pend = np;
    for (int k = 0; k < 8; k++) m_smp[k] = ch[k];
    if (lost && m_ovf < 65535) m_ovf++;
  endtask

  task automatic check_all();
    check_eq("valid", valid, m_valid);
    if (m_valid) begin
      check_eq("idx", idx, m_idx);
      check_eq("data", data, m_data);
    end
    check_eq("pend", pend, m_pend);
`ifdef REG_BANK_SCANNER_OVF_EN
    check_eq("ovf", ovf, m_ovf);
`else
    check_eq("ovf", ovf, 0);
`endif
  endtask

  // Advance one cycle: model follows the edge, outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 8; k++) ch[k] = 8'h00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    model_reset();
    @(negedge clk);
    do_reset();

    // Quiet bank: nothing should be reported.
    for (int i = 0; i < 10; i++) begin
      cycle();
      check_eq("idle_valid", valid, 0);
      check_eq("idle_pend", pend, 8'h00);
    end

    // Single change on channel 2: valid two cycles later, for one cycle.
    ch[2] = 8'h5A;
    rdy   = 1'b1;
    cycle();
    check_eq("c_pend", pend, 8'h04);
    check_eq("c_valid0", valid, 0);
    cycle();
    check_eq("c_valid", valid, 1);
    check_eq("c_idx", idx, 2);
    check_eq("c_data", data, 8'h5A);
    cycle();
    check_eq("c_drop", valid, 0);

    // Three simultaneous changes, consumer always ready: back-to-back records.
    clear_inputs();
    do_reset();
    ch[1] = 8'h11; ch[4] = 8'h44; ch[6] = 8'h66;
    cycle();
    check_eq("b2b_pend", pend, 8'h52);
    cycle();
    check_eq("b2b_idx1", idx, 1);
    check_eq("b2b_dat1", data, 8'h11);
    cycle();
    check_eq("b2b_idx4", idx, 4);
    check_eq("b2b_v4", valid, 1);
    cycle();
    check_eq("b2b_idx6", idx, 6);
    check_eq("b2b_dat6", data, 8'h66);
    cycle();
    check_eq("b2b_drop", valid, 0);

    // Same with a 5-cycle stall: first record must hold steady.
    clear_inputs();
    do_reset();
    ch[1] = 8'h21; ch[4] = 8'h24; ch[6] = 8'h26;
    rdy = 1'b0;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("stall_valid", valid, 1);
      check_eq("stall_idx", idx, 1);
      check_eq("stall_data", data, 8'h21);
    end
    rdy = 1'b1;
    cycle();
    check_eq("stall_idx4", idx, 4);
    cycle();
    check_eq("stall_idx6", idx, 6);
    cycle();
    check_eq("stall_drop", valid, 0);

    // Channel 4 changes three times while the stream is stalled.
    clear_inputs();
    do_reset();
    ch[1] = 8'h07;
    rdy   = 1'b0;
    cycle();
    cycle();
    check_eq("col_idx1", idx, 1);
    ch[4] = 8'h01; cycle();
    ch[4] = 8'h02; cycle();
    ch[4] = 8'h03; cycle();
`ifdef REG_BANK_SCANNER_OVF_EN
    check_eq("col_ovf", ovf, 2);
`else
    check_eq("col_ovf", ovf, 0);
`endif
    rdy = 1'b1;
    cycle();
    check_eq("col_idx4", idx, 4);
    check_eq("col_data", data, 8'h03);
    cycle();
    check_eq("col_drop", valid, 0);

    // Reset while a record is offered and others are pending.
    clear_inputs();
    do_reset();
    ch[2] = 8'hA2; ch[5] = 8'hA5; ch[7] = 8'hA7;
    rdy = 1'b0;
    cycle();
    cycle();
    check_eq("rst_pre_valid", valid, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_valid", valid, 0);
    check_eq("rst_idx", idx, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_pend", pend, 0);
    check_eq("rst_ovf", ovf, 0);
    cycle();
    rst_n = 1'b1;
    rdy   = 1'b1;
    cycle();
    check_eq("rst_re_pend", pend, 8'hA4);
    cycle();
    check_eq("rst_re_idx2", idx, 2);
    cycle();
    check_eq("rst_re_idx5", idx, 5);
    cycle();
    check_eq("rst_re_idx7", idx, 7);
    check_eq("rst_re_data7", data, 8'hA7);

    // Random channel activity and back-pressure.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 8; k++)
        if ($urandom_range(0, 5) == 0) ch[k] = 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
